// File: rtl/hippo_mdu_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
// Imported by hippo_mdu and by the execute-stage decoder.
package hippo_mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mdu_state_e;

  function automatic logic is_div(input mdu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic a_signed(input mdu_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_signed(input mdu_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/hippo_mdu.sv
// Iterative RISC-V M-extension unit: one shift-add or restoring-divide step per
// cycle on a shared 2*WIDTH accumulator, with valid/ready on both sides.
module hippo_mdu
  import hippo_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned AW = 2 * WIDTH;

  mdu_state_e       r_state, w_state_nxt;
  mdu_op_e          r_op, w_op_nxt;
  logic             r_neg, w_neg_nxt;
  logic [WIDTH-1:0] r_opb, w_opb_nxt;
  logic [AW-1:0]    r_acc, w_acc_nxt;
  logic [WIDTH:0]   r_rem, w_rem_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_res, w_res_nxt;

  // Operand decode and magnitudes at accept time
  mdu_op_e          w_in_op;
  logic             w_a_neg, w_b_neg, w_div0, w_ovf;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_min;

  assign w_in_op = mdu_op_e'(op);
  assign w_a_neg = a_signed(w_in_op) & a[WIDTH-1];
  assign w_b_neg = b_signed(w_in_op) & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~a + WIDTH'(1)) : a;
  assign w_b_mag = w_b_neg ? (~b + WIDTH'(1)) : b;
  assign w_min   = {1'b1, {(WIDTH-1){1'b0}}};
  assign w_div0  = is_div(w_in_op) && (b == '0);
  assign w_ovf   = (w_in_op inside {OP_DIV, OP_REM}) && (a == w_min) && (b == '1);

  // Multiply step: add multiplicand into the high word when the low bit is set, then shift right
  logic [WIDTH:0]   w_mul_sum;
  logic [AW-1:0]    w_mul_acc;
  assign w_mul_sum = {1'b0, r_acc[AW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide step: quotient bits shift into the low word as dividend bits shift out
  logic [WIDTH:0]   w_rem_sh, w_trial, w_div_rem;
  logic             w_qbit;
  logic [AW-1:0]    w_div_acc;
  assign w_rem_sh  = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
  assign w_trial   = w_rem_sh - {1'b0, r_opb};
  assign w_qbit    = ~w_trial[WIDTH];
  assign w_div_rem = w_qbit ? w_trial : w_rem_sh;
  assign w_div_acc = {r_acc[AW-1:WIDTH], r_acc[WIDTH-2:0], w_qbit};

  // Sign-corrected results of the final step
  logic [AW-1:0]    w_prod;
  logic [WIDTH-1:0] w_quo, w_remv, w_final;
  assign w_prod = r_neg ? (~w_mul_acc + AW'(1)) : w_mul_acc;
  assign w_quo  = r_neg ? (~w_div_acc[WIDTH-1:0] + WIDTH'(1)) : w_div_acc[WIDTH-1:0];
  assign w_remv = r_neg ? (~w_div_rem[WIDTH-1:0] + WIDTH'(1)) : w_div_rem[WIDTH-1:0];

  always_comb begin
    case (r_op)
      OP_MUL:                        w_final = w_prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_final = w_prod[AW-1:WIDTH];
      OP_DIV, OP_DIVU:               w_final = w_quo;
      default:                       w_final = w_remv;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_neg_nxt   = r_neg;
    w_opb_nxt   = r_opb;
    w_acc_nxt   = r_acc;
    w_rem_nxt   = r_rem;
    w_cnt_nxt   = r_cnt;
    w_res_nxt   = r_res;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_op_nxt  = w_in_op;
          w_neg_nxt = (w_in_op inside {OP_REM, OP_REMU}) ? w_a_neg : (w_a_neg ^ w_b_neg);
          w_rem_nxt = '0;
          if (is_div(w_in_op)) begin
            w_opb_nxt = w_b_mag;
            w_acc_nxt = {{WIDTH{1'b0}}, w_a_mag};
          end else begin
            w_opb_nxt = w_a_mag;
            w_acc_nxt = {{WIDTH{1'b0}}, w_b_mag};
          end
          if (w_div0) begin
            w_res_nxt   = (w_in_op inside {OP_REM, OP_REMU}) ? a : '1;
            w_state_nxt = S_DONE;
          end else if (w_ovf) begin
            w_res_nxt   = (w_in_op == OP_DIV) ? w_min : '0;
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt   = CW'(WIDTH);
            w_state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        w_acc_nxt = is_div(r_op) ? w_div_acc : w_mul_acc;
        w_rem_nxt = is_div(r_op) ? w_div_rem : r_rem;
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_res_nxt   = w_final;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort leaves the last delivered result visible
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_res_nxt   = r_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_MUL;
      r_neg   <= 1'b0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_neg   <= w_neg_nxt;
      r_opb   <= w_opb_nxt;
      r_acc   <= w_acc_nxt;
      r_rem   <= w_rem_nxt;
      r_cnt   <= w_cnt_nxt;
      r_res   <= w_res_nxt;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign res       = r_res;

endmodule

// File: tb/tb_hippo_mdu.sv
// Directed self-checking bench for hippo_mdu at WIDTH=32.
module tb_hippo_mdu;
  import hippo_mdu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [2:0]   op;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;

  int n_chk = 0;
  int n_err = 0;

  hippo_mdu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one op, measure latency, check result, optionally hold in DONE, then consume
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] exp, input int exp_lat,
                        input int hold);
    int lat;
    int rdy_busy;
    @(negedge clk);
    check({tag, "_in_ready"}, W'(in_ready), W'(1));
    in_valid = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    in_valid = 1'b0; a = '0; b = '0; op = '0;
    lat = 1;
    rdy_busy = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_busy++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, W'(lat), W'(exp_lat));
    check({tag, "_busy_rdy"}, W'(rdy_busy), W'(0));
    check({tag, "_res"}, res, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_res"}, res, exp);
      check({tag, "_hold_valid"}, W'(out_valid), W'(1));
      check({tag, "_hold_rdy"}, W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, W'(out_valid), W'(0));
    check({tag, "_drain_rdy"}, W'(in_ready), W'(1));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_res", res, '0);

    run_op("mul_3x5",    OP_MUL,    32'd3,          32'd5,          32'd15,         33, 0);
    run_op("mulh_n3x5",  OP_MULH,   32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF,   33, 0);
    run_op("mulhu_fd5",  OP_MULHU,  32'hFFFFFFFD,   32'd5,          32'h00000004,   33, 5);
    run_op("mulhsu_n35", OP_MULHSU, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF,   33, 0);
    run_op("mulhu_max",  OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   33, 0);
    run_op("div_n12_5",  OP_DIV,    32'hFFFFFFF4,   32'd5,          32'hFFFFFFFE,   33, 0);
    run_op("rem_n12_5",  OP_REM,    32'hFFFFFFF4,   32'd5,          32'hFFFFFFFE,   33, 0);
    run_op("divu_12_5",  OP_DIVU,   32'd12,         32'd5,          32'd2,          33, 0);
    run_op("remu_12_5",  OP_REMU,   32'd12,         32'd5,          32'd2,          33, 0);
    run_op("div_7_0",    OP_DIV,    32'd7,          32'd0,          32'hFFFFFFFF,   1,  0);
    run_op("rem_7_0",    OP_REM,    32'd7,          32'd0,          32'd7,          1,  0);
    run_op("div_ovf",    OP_DIV,    32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1,  0);
    run_op("rem_ovf",    OP_REM,    32'h80000000,   32'hFFFFFFFF,   32'd0,          1,  0);
    run_op("divu_big",   OP_DIVU,   32'h80000000,   32'hFFFFFFFF,   32'd0,          33, 0);
    run_op("remu_big",   OP_REMU,   32'h80000000,   32'hFFFFFFFF,   32'h80000000,   33, 0);

    // Flush at BUSY cycle 10: back to IDLE, no result, res keeps last value
    @(negedge clk);
    in_valid = 1'b1; op = OP_MUL; a = 32'd100; b = 32'd100;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_in_ready", W'(in_ready), W'(1));
    check("flush_out_valid", W'(out_valid), W'(0));
    check("flush_res", res, 32'h80000000);
    repeat (40) begin
      @(negedge clk);
      if (out_valid) check("flush_late_valid", W'(out_valid), W'(0));
    end
    run_op("mul_2x2", OP_MUL, 32'd2, 32'd2, 32'd4, 33, 0);

    // Flush together with in_valid in IDLE: nothing accepted
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = OP_DIV; a = 32'd7; b = 32'd0;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept_rdy", W'(in_ready), W'(1));
    check("flush_accept_valid", W'(out_valid), W'(0));
    check("flush_accept_res", res, 32'd4);

    // Reset mid-BUSY
    in_valid = 1'b1; op = OP_MUL; a = 32'd9; b = 32'd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", W'(in_ready), W'(1));
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_res", res, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hippo_mdu.md
# hippo_mdu

Iterative multiply/divide unit implementing the RISC-V M-extension operations at a parametrised operand width. It sits beside the combinational ALU in the execute stage and handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. It computes one bit per cycle on a shared shift datapath. A valid/ready handshake on both sides lets the pipeline stall while a result is in flight.

## Interface
Parameters:
- WIDTH, 32: operand and result width in bits; must be ≥ 4.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  unit can accept a new operation this cycle.
- a  input  WIDTH  first operand (multiplicand / dividend).
- b  input  WIDTH  second operand (multiplier / divisor).
- op  input  3  MDUOp, encoded as RISC-V funct3 (MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7).
- flush  input  1  abort the in-flight operation.
- out_valid  output  1  res holds a completed result.
- out_ready  input  1  consumer takes the result this cycle.
- res  output  WIDTH  result.

## Operation
- States: IDLE, BUSY, DONE.
- in_ready is high only in IDLE. out_valid is high only in DONE.
- **IDLE:** on in_valid, capture op and the operand magnitudes.
  - Signedness: a is signed for MULH, MULHSU, DIV, REM. b is signed for MULH, DIV, REM.
  - Record the result sign:
    - Products: sign(a) XOR sign(b).
    - Quotient: sign(a) XOR sign(b).
    - Remainder: sign of dividend a.
  - Load counter = WIDTH and go to BUSY.
- **IDLE special cases** go straight to DONE and skip BUSY:
  - Divide by zero (b==0, op DIV/DIVU/REM/REMU): quotient = all ones; remainder = a unmodified.
  - Signed overflow (DIV/REM, a==MIN, b==all ones): quotient = MIN, remainder = 0.
- **BUSY, multiply:** one shift-add step per cycle into a 2·WIDTH accumulator.
- **BUSY, divide:** one restoring-division step per cycle.
- **BUSY, finish:** the counter decrements each cycle. On the step where it reaches 0:
  - Apply sign correction (two's-complement negate when the recorded sign is 1).
  - Select the result: low word for MUL, high word for MULH*, quotient for DIV*, remainder for REM*.
  - Register it into res and go to DONE.
- **DONE:** hold res and out_valid stable until out_ready, then go to IDLE.
  - A new operation cannot be accepted in the same cycle as the DONE→IDLE transition.
- **flush:** any state goes to IDLE on the next edge and out_valid drops.
  - res is left unchanged.
  - flush and in_valid together in IDLE: flush wins and nothing is accepted.
- Width rules:
  - All magnitudes are WIDTH bits unsigned.
  - Accumulator is 2·WIDTH bits.
  - Remainder register is WIDTH+1 bits, to hold the trial-subtract borrow.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, res 0, counter 0.
- rst overrides everything, including mid-BUSY and mid-DONE.
- Accept happens in cycle C0 (in_valid && in_ready).
- Normal operations:
  - BUSY occupies C1..C_WIDTH.
  - out_valid first high in C_(WIDTH+1), i.e. latency WIDTH+1 cycles.
- Special cases: out_valid high in C1 (latency 1).
- Throughput: at most one operation per WIDTH+2 cycles (accept, WIDTH steps, DONE, IDLE).
- res changes only on the edge that enters DONE.

## Structure
- Shared package hippo_mdu_pkg holds:
  - MDUOp enum (3-bit, funct3 values above).
  - MDUState enum.
  - Helper functions: is_div(op), a_signed(op), b_signed(op).
- The execute-stage decoder imports hippo_mdu_pkg.
- No sub-module: multiply and divide share the accumulator and counter in one module. The datapath plus FSM is roughly 200–300 lines.

## Test plan
All cases use WIDTH=32.
- **MUL latency:** MUL a=3, b=5 → res=15; out_valid first high exactly 33 cycles after accept; in_ready low throughout.
- **High products:** MULH a=-3, b=5 → 0xFFFFFFFF; MULHU a=0xFFFFFFFD, b=5 → 0x00000004; MULHSU a=-3, b=5 → 0xFFFFFFFF.
- **Signed/unsigned divide:** DIV -12/5 → 0xFFFFFFFE; REM -12%5 → 0xFFFFFFFE; DIVU 12/5 → 2; REMU 12%5 → 2.
- **Special cases:**
  - DIV 7/0 → 0xFFFFFFFF; REM 7%0 → 7; both with out_valid in cycle 1 after accept.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- **Backpressure and flush:**
  - Hold out_ready low 5 cycles in DONE → res and out_valid stable, in_ready low.
  - Assert flush at BUSY cycle 10 → IDLE next cycle, no out_valid; a following MUL 2×2 returns 4.
- **Reset:** assert rst mid-BUSY → next cycle in_ready=1, out_valid=0, res=0.
